// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state geometry and ShiftRows rotation tables.
//   STATE_W / BYTE_W / NUM_BYTES : state is 16 bytes of 8 bits
//   byte_idx(row, col)           : column-major byte index, byte 0 in MSBs
//   FWD_SHIFT / INV_SHIFT        : left-rotation amount per row
package aes_pkg;

  localparam int STATE_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = STATE_W / BYTE_W;
  localparam int NUM_ROWS  = 4;

  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [STATE_W-1:0] state_t;

  // Element [r] is the left-rotation for row r. Inverse rotates right by r,
  // which is the same as rotating left by (4 - r) mod 4.
  localparam logic [NUM_ROWS-1:0][1:0] FWD_SHIFT = '{2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [NUM_ROWS-1:0][1:0] INV_SHIFT = '{2'd1, 2'd2, 2'd3, 2'd0};

  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: pure combinational AES ShiftRows / InvShiftRows byte
// permutation. No clock.
//   inv       : 0 = forward (rotate row r left by r), 1 = inverse
//   state_in  : 128-bit state, byte k at [127-8k -: 8]
//   state_out : permuted state, same byte ordering
module shift_rows_perm
  import aes_pkg::*;
(
  input  logic               inv,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out
);

  // Each output byte is a fixed wire pick from one of two source bytes;
  // the source indices are resolved at elaboration time.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
    localparam int R  = k % NUM_ROWS;
    localparam int C  = k / NUM_ROWS;
    localparam int FS = byte_idx(R, (C + int'(FWD_SHIFT[R])) % NUM_ROWS);
    localparam int IS = byte_idx(R, (C + int'(INV_SHIFT[R])) % NUM_ROWS);

    assign state_out[STATE_W-1-BYTE_W*k -: BYTE_W] =
      inv ? state_in[STATE_W-1-BYTE_W*IS -: BYTE_W]
          : state_in[STATE_W-1-BYTE_W*FS -: BYTE_W];
  end

endmodule

// File: rtl/shift_rows.sv
// shift_rows: AES ShiftRows / InvShiftRows stage with valid flag.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   in_valid  : qualifies inv/state_in this cycle
//   inv       : 0 = ShiftRows, 1 = InvShiftRows
//   state_in  : 128-bit AES state
//   out_valid : state_out carries a freshly transformed state
//   state_out : permuted state
// REG_OUT=1 gives a 1-cycle registered stage; REG_OUT=0 is combinational.
module shift_rows
  import aes_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               inv,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  output logic [STATE_W-1:0] state_out
);

  logic [STATE_W-1:0] perm;

  shift_rows_perm u_perm (
    .inv       (inv),
    .state_in  (state_in),
    .state_out (perm)
  );

  if (REG_OUT != 0) begin : g_reg
    logic [STATE_W-1:0] state_q;
    logic               vld_q;

    // The state register only loads on in_valid, so garbage on state_in
    // during idle cycles never reaches the output.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= '0;
        vld_q   <= 1'b0;
      end else if (in_valid) begin
        state_q <= perm;
        vld_q   <= 1'b1;
      end else begin
        vld_q   <= 1'b0;
      end
    end

    assign state_out = state_q;
    assign out_valid = vld_q;
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk;
    assign state_out  = perm;
    assign out_valid  = in_valid & ~rst;
  end

endmodule

// File: tb/tb_shift_rows.sv
// tb_shift_rows: self-checking bench for shift_rows (REG_OUT=1).
module tb_shift_rows;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         inv;
  logic [127:0] state_in;
  logic         out_valid;
  logic [127:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  shift_rows #(.REG_OUT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inv       (inv),
    .state_in  (state_in),
    .out_valid (out_valid),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  // Reference: treat the state as a 4x4 byte matrix (row = k%4, col = k/4)
  // and rotate each row by its index, left for forward, right for inverse.
  function automatic logic [127:0] ref_perm(input logic [127:0] s, input logic dir_inv);
    logic [7:0] m [4][4];
    logic [7:0] o [4][4];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127 - 8*k -: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        o[row][col] = dir_inv ? m[row][(col - row + 4) % 4] : m[row][(col + row) % 4];
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = o[k % 4][k / 4];
    return r;
  endfunction

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance one clock and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t         tbl [4];
  logic [127:0] held;
  logic [127:0] x, y, e;
  logic         v, d;

  initial begin
    tbl[0] = '{1'b0, 128'h000102030405060708090A0B0C0D0E0F, 128'h00050A0F04090E03080D02070C01060B};
    tbl[1] = '{1'b0, 128'hD42711AEE0BF98F1B8B45DE51E415230, 128'hD4BF5D30E0B452AEB84111F11E2798E5};
    tbl[2] = '{1'b1, 128'h00050A0F04090E03080D02070C01060B, 128'h000102030405060708090A0B0C0D0E0F};
    tbl[3] = '{1'b1, 128'hD4BF5D30E0B452AEB84111F11E2798E5, 128'hD42711AEE0BF98F1B8B45DE51E415230};

    // Reset dominates in_valid for two cycles.
    rst = 1'b1; in_valid = 1'b1; inv = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      tick();
      chk128("reset_state", state_out, 128'h0);
      chk1("reset_valid", out_valid, 1'b0);
    end

    // First edge after release with in_valid produces a valid result.
    @(negedge clk);
    rst = 1'b0; state_in = tbl[0].din; inv = tbl[0].inv;
    tick();
    chk128("post_reset_state", state_out, tbl[0].exp);
    chk1("post_reset_valid", out_valid, 1'b1);

    // Directed vectors.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; inv = tbl[i].inv; state_in = tbl[i].din;
      tick();
      chk128($sformatf("vec%0d_state", i), state_out, tbl[i].exp);
      chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
    end

    // Back-to-back stream, then idle with inv flipping and garbage data.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; inv = tbl[i+1].inv; state_in = tbl[i+1].din;
      tick();
      chk128($sformatf("stream%0d_state", i), state_out, tbl[i+1].exp);
      chk1($sformatf("stream%0d_valid", i), out_valid, 1'b1);
    end
    held = tbl[3].exp;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; inv = ~inv;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk128($sformatf("hold%0d_state", i), state_out, held);
      chk1($sformatf("hold%0d_valid", i), out_valid, 1'b0);
    end

    // Random traffic with idle gaps, alternating direction on valid beats.
    d = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      v = ($urandom_range(0, 3) != 0);
      in_valid = v; inv = d; state_in = x;
      if (v) begin
        held = ref_perm(x, d);
        d = ~d;
      end
      tick();
      chk128("rand_state", state_out, held);
      chk1("rand_valid", out_valid, v);
    end

    // Round trip through the DUT: inverse of forward restores the input.
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; inv = 1'b0; state_in = x;
      tick();
      y = state_out;
      e = ref_perm(x, 1'b0);
      chk128("rt_fwd", y, e);
      inv = 1'b1; state_in = y;
      tick();
      chk128("rt_inv", state_out, x);
    end

    // Reset mid-stream clears a held value.
    in_valid = 1'b1; rst = 1'b1; state_in = tbl[1].din; inv = 1'b0;
    tick();
    chk128("late_reset_state", state_out, 128'h0);
    chk1("late_reset_valid", out_valid, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
